// File: rtl/eth_cfg_ll_if.sv
// LocalLink 8-bit receive channel (active-low framing) between a source and a sink.
interface eth_cfg_ll_if;
  logic [7:0] data_in;
  logic       sof_n;
  logic       eof_n;
  logic       src_rdy_n;
  logic       dst_rdy_n;

  modport master (output data_in, sof_n, eof_n, src_rdy_n, input dst_rdy_n);
  modport slave  (input data_in, sof_n, eof_n, src_rdy_n, output dst_rdy_n);
endinterface

// File: rtl/eth_cfg_parser.sv
// Config-packet parser on the LocalLink RX path: shadow capture, atomic commit on a valid frame.
// Define ETH_CFG_CSUM_EN to require an XOR checksum byte after the last channel record.
module eth_cfg_parser #(
  parameter int          NUM_CH      = 4,
  parameter int          HDR_OFFSET  = 42,
  parameter logic [31:0] MAGIC       = 32'hDEADBEEF,
  parameter int          TIMEOUT_CYC = 16000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  eth_cfg_ll_if.slave          ll,
  output logic [7:0]           gen_num_ch,
  output logic [23:0]          gen_spare,
  output logic [32*NUM_CH-1:0] ch_threshold,
  output logic [8*NUM_CH-1:0]  ch_fft_size,
  output logic [8*NUM_CH-1:0]  ch_mode,
  output logic [32*NUM_CH-1:0] ch_frequency,
  output logic [16*NUM_CH-1:0] ch_spare,
  output logic                 cfg_valid,
  output logic                 cfg_err,
  output logic [2:0]           err_code,
  output logic [15:0]          good_cnt,
  output logic [15:0]          bad_cnt
);
  localparam int          CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [31:0] HO = 32'(HDR_OFFSET);
`ifdef ETH_CFG_CSUM_EN
  localparam logic [31:0] CSUM_LEN = 32'd1;
`else
  localparam logic [31:0] CSUM_LEN = 32'd0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_CHECK} state_t;

  state_t               state_q, state_d;
  logic                 dst_rdy_n_q, dst_rdy_n_d;
  logic [15:0]          byte_idx_q, byte_idx_d, last_idx_q, last_idx_d;
  logic [CW-1:0]        idle_q, idle_d;
  logic [31:0]          sh_magic_q, sh_magic_d;
  logic [7:0]           sh_num_ch_q, sh_num_ch_d;
  logic [23:0]          sh_spare_q, sh_spare_d;
  logic [32*NUM_CH-1:0] sh_thr_q, sh_thr_d, sh_freq_q, sh_freq_d;
  logic [8*NUM_CH-1:0]  sh_fft_q, sh_fft_d, sh_mode_q, sh_mode_d;
  logic [16*NUM_CH-1:0] sh_csp_q, sh_csp_d;
  logic [7:0]           gen_num_ch_q, gen_num_ch_d;
  logic [23:0]          gen_spare_q, gen_spare_d;
  logic [32*NUM_CH-1:0] ch_thr_q, ch_thr_d, ch_freq_q, ch_freq_d;
  logic [8*NUM_CH-1:0]  ch_fft_q, ch_fft_d, ch_mode_q, ch_mode_d;
  logic [16*NUM_CH-1:0] ch_csp_q, ch_csp_d;
  logic                 cfg_valid_q, cfg_valid_d, cfg_err_q, cfg_err_d;
  logic [2:0]           err_code_q, err_code_d;
  logic [15:0]          good_cnt_q, good_cnt_d, bad_cnt_q, bad_cnt_d;
`ifdef ETH_CFG_CSUM_EN
  logic [7:0]           csum_acc_q, csum_acc_d, csum_byte_q, csum_byte_d;
`endif

  logic        beat, cap, rej, commit;
  logic [2:0]  rej_code;
  logic [15:0] cur_idx;
  logic [31:0] idx32, rec_end;

  always_comb begin
    beat    = !ll.src_rdy_n && !dst_rdy_n_q;
    cap     = beat && ((state_q == S_IDLE && !ll.sof_n) || state_q == S_RECV);
    cur_idx = !ll.sof_n ? 16'd0 : byte_idx_q;
    idx32   = {16'd0, cur_idx};
    // Index of the last byte of record num_ch-1 (end of general header when num_ch is 0).
    rec_end = HO + 32'd7 + 32'd12 * {24'd0, sh_num_ch_q};

    state_d      = state_q;
    byte_idx_d   = byte_idx_q;
    last_idx_d   = last_idx_q;
    idle_d       = (state_q == S_RECV && !beat) ? idle_q + CW'(1) : '0;
    sh_magic_d   = sh_magic_q;
    sh_num_ch_d  = sh_num_ch_q;
    sh_spare_d   = sh_spare_q;
    sh_thr_d     = sh_thr_q;
    sh_fft_d     = sh_fft_q;
    sh_mode_d    = sh_mode_q;
    sh_freq_d    = sh_freq_q;
    sh_csp_d     = sh_csp_q;
    gen_num_ch_d = gen_num_ch_q;
    gen_spare_d  = gen_spare_q;
    ch_thr_d     = ch_thr_q;
    ch_fft_d     = ch_fft_q;
    ch_mode_d    = ch_mode_q;
    ch_freq_d    = ch_freq_q;
    ch_csp_d     = ch_csp_q;
    rej          = 1'b0;
    rej_code     = 3'd0;
    commit       = 1'b0;
`ifdef ETH_CFG_CSUM_EN
    csum_acc_d   = csum_acc_q;
    csum_byte_d  = csum_byte_q;
`endif

    // A fresh frame must not inherit a matching magic word or checksum from the previous one.
    if (cap && !ll.sof_n) begin
      sh_magic_d = '0;
`ifdef ETH_CFG_CSUM_EN
      csum_acc_d  = '0;
      csum_byte_d = '0;
`endif
    end

    if (cap) begin
      byte_idx_d = (cur_idx == 16'hFFFF) ? cur_idx : cur_idx + 16'd1;
      if (!ll.eof_n) last_idx_d = cur_idx;
      for (int j = 0; j < 4; j++)
        if (idx32 == HO + 32'(j)) sh_magic_d[8*(3-j) +: 8] = ll.data_in;
      if (idx32 == HO + 32'd4) sh_num_ch_d = ll.data_in;
      for (int j = 0; j < 3; j++)
        if (idx32 == HO + 32'(5 + j)) sh_spare_d[8*(2-j) +: 8] = ll.data_in;
      for (int k = 0; k < NUM_CH; k++) begin
        for (int j = 0; j < 4; j++) begin
          if (idx32 == HO + 32'(8 + 12*k + j)) sh_thr_d[32*k + 8*(3-j) +: 8] = ll.data_in;
          if (idx32 == HO + 32'(14 + 12*k + j)) sh_freq_d[32*k + 8*(3-j) +: 8] = ll.data_in;
        end
        if (idx32 == HO + 32'(12 + 12*k)) sh_fft_d[8*k +: 8] = ll.data_in;
        if (idx32 == HO + 32'(13 + 12*k)) sh_mode_d[8*k +: 8] = ll.data_in;
        for (int j = 0; j < 2; j++)
          if (idx32 == HO + 32'(18 + 12*k + j)) sh_csp_d[16*k + 8*(1-j) +: 8] = ll.data_in;
      end
`ifdef ETH_CFG_CSUM_EN
      // Bytes up to num_ch use the header-only bound; later ones use the captured num_ch.
      if (idx32 >= HO) begin
        if (idx32 <= HO + 32'd4 || idx32 <= rec_end) csum_acc_d = csum_acc_d ^ ll.data_in;
        else if (idx32 == rec_end + 32'd1) csum_byte_d = ll.data_in;
      end
`endif
    end

    case (state_q)
      S_IDLE: if (cap) state_d = ll.eof_n ? S_RECV : S_CHECK;
      S_RECV: begin
        if (beat) begin
          if (!ll.sof_n) begin
            rej      = 1'b1;
            rej_code = 3'd4;
          end
          if (!ll.eof_n) state_d = S_CHECK;
        end else if (idle_q == CW'(TIMEOUT_CYC - 1)) begin
          state_d  = S_IDLE;
          rej      = 1'b1;
          rej_code = 3'd5;
        end
      end
      S_CHECK: begin
        state_d = S_IDLE;
        rej     = 1'b1;
        if (sh_magic_q != MAGIC) rej_code = 3'd1;
        else if (sh_num_ch_q == 8'd0 || 32'(sh_num_ch_q) > 32'(NUM_CH)) rej_code = 3'd2;
        else if ({16'd0, last_idx_q} < rec_end + CSUM_LEN) rej_code = 3'd3;
`ifdef ETH_CFG_CSUM_EN
        else if (csum_acc_q != csum_byte_q) rej_code = 3'd6;
`endif
        else begin
          rej    = 1'b0;
          commit = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (commit) begin
      gen_num_ch_d = sh_num_ch_q;
      gen_spare_d  = sh_spare_q;
      for (int k = 0; k < NUM_CH; k++)
        if (32'(k) < 32'(sh_num_ch_q)) begin
          ch_thr_d[32*k +: 32]  = sh_thr_q[32*k +: 32];
          ch_fft_d[8*k +: 8]    = sh_fft_q[8*k +: 8];
          ch_mode_d[8*k +: 8]   = sh_mode_q[8*k +: 8];
          ch_freq_d[32*k +: 32] = sh_freq_q[32*k +: 32];
          ch_csp_d[16*k +: 16]  = sh_csp_q[16*k +: 16];
        end
    end

    cfg_valid_d = commit;
    cfg_err_d   = rej;
    err_code_d  = rej ? rej_code : err_code_q;
    good_cnt_d  = good_cnt_q + {15'd0, commit};
    bad_cnt_d   = bad_cnt_q + {15'd0, rej};
    dst_rdy_n_d = (state_d == S_CHECK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      dst_rdy_n_q  <= 1'b1;
      byte_idx_q   <= '0;
      last_idx_q   <= '0;
      idle_q       <= '0;
      sh_magic_q   <= '0;
      sh_num_ch_q  <= '0;
      sh_spare_q   <= '0;
      sh_thr_q     <= '0;
      sh_fft_q     <= '0;
      sh_mode_q    <= '0;
      sh_freq_q    <= '0;
      sh_csp_q     <= '0;
      gen_num_ch_q <= '0;
      gen_spare_q  <= '0;
      ch_thr_q     <= '0;
      ch_fft_q     <= '0;
      ch_mode_q    <= '0;
      ch_freq_q    <= '0;
      ch_csp_q     <= '0;
      cfg_valid_q  <= 1'b0;
      cfg_err_q    <= 1'b0;
      err_code_q   <= '0;
      good_cnt_q   <= '0;
      bad_cnt_q    <= '0;
`ifdef ETH_CFG_CSUM_EN
      csum_acc_q   <= '0;
      csum_byte_q  <= '0;
`endif
    end else begin
      state_q      <= state_d;
      dst_rdy_n_q  <= dst_rdy_n_d;
      byte_idx_q   <= byte_idx_d;
      last_idx_q   <= last_idx_d;
      idle_q       <= idle_d;
      sh_magic_q   <= sh_magic_d;
      sh_num_ch_q  <= sh_num_ch_d;
      sh_spare_q   <= sh_spare_d;
      sh_thr_q     <= sh_thr_d;
      sh_fft_q     <= sh_fft_d;
      sh_mode_q    <= sh_mode_d;
      sh_freq_q    <= sh_freq_d;
      sh_csp_q     <= sh_csp_d;
      gen_num_ch_q <= gen_num_ch_d;
      gen_spare_q  <= gen_spare_d;
      ch_thr_q     <= ch_thr_d;
      ch_fft_q     <= ch_fft_d;
      ch_mode_q    <= ch_mode_d;
      ch_freq_q    <= ch_freq_d;
      ch_csp_q     <= ch_csp_d;
      cfg_valid_q  <= cfg_valid_d;
      cfg_err_q    <= cfg_err_d;
      err_code_q   <= err_code_d;
      good_cnt_q   <= good_cnt_d;
      bad_cnt_q    <= bad_cnt_d;
`ifdef ETH_CFG_CSUM_EN
      csum_acc_q   <= csum_acc_d;
      csum_byte_q  <= csum_byte_d;
`endif
    end
  end

  assign ll.dst_rdy_n   = dst_rdy_n_q;
  assign gen_num_ch     = gen_num_ch_q;
  assign gen_spare      = gen_spare_q;
  assign ch_threshold   = ch_thr_q;
  assign ch_fft_size    = ch_fft_q;
  assign ch_mode        = ch_mode_q;
  assign ch_frequency   = ch_freq_q;
  assign ch_spare       = ch_csp_q;
  assign cfg_valid      = cfg_valid_q;
  assign cfg_err        = cfg_err_q;
  assign err_code       = err_code_q;
  assign good_cnt       = good_cnt_q;
  assign bad_cnt        = bad_cnt_q;
endmodule

// File: tb/tb_eth_cfg_parser.sv
// Scoreboard bench for eth_cfg_parser: frames are built as byte queues, a byte-level model predicts each outcome.
module tb_eth_cfg_parser;
  localparam int          NCH   = 4;
  localparam int          HO    = 42;
  localparam int          TO    = 16000;
  localparam logic [31:0] MAGIC = 32'hDEADBEEF;
`ifdef ETH_CFG_CSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  eth_cfg_ll_if ll();

  logic [7:0]        gen_num_ch;
  logic [23:0]       gen_spare;
  logic [32*NCH-1:0] ch_threshold, ch_frequency;
  logic [8*NCH-1:0]  ch_fft_size, ch_mode;
  logic [16*NCH-1:0] ch_spare;
  logic              cfg_valid, cfg_err;
  logic [2:0]        err_code;
  logic [15:0]       good_cnt, bad_cnt;

  eth_cfg_parser #(.NUM_CH(NCH), .HDR_OFFSET(HO), .MAGIC(MAGIC), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .ll(ll),
    .gen_num_ch(gen_num_ch), .gen_spare(gen_spare),
    .ch_threshold(ch_threshold), .ch_fft_size(ch_fft_size), .ch_mode(ch_mode),
    .ch_frequency(ch_frequency), .ch_spare(ch_spare),
    .cfg_valid(cfg_valid), .cfg_err(cfg_err), .err_code(err_code),
    .good_cnt(good_cnt), .bad_cnt(bad_cnt)
  );

  typedef struct {
    logic              err;
    logic [2:0]        code;
    logic [15:0]       good, bad;
    logic [7:0]        nch;
    logic [23:0]       sp;
    logic [32*NCH-1:0] thr, freq;
    logic [8*NCH-1:0]  fft, mode;
    logic [16*NCH-1:0] csp;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       m;
  logic [7:0] frm[$];
  logic [31:0] r_thr[8], r_freq[8];
  logic [7:0]  r_fft[8], r_mode[8];
  logic [15:0] r_sp[8];
  logic [23:0] g_sp;
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, want);
    end
  endtask

  task automatic set_rec(input int k, input logic [31:0] thr, input logic [7:0] fft,
                         input logic [7:0] mode, input logic [31:0] freq, input logic [15:0] sp);
    r_thr[k] = thr; r_fft[k] = fft; r_mode[k] = mode; r_freq[k] = freq; r_sp[k] = sp;
  endtask

  task automatic build(input logic [31:0] mg, input int nch_field, input int nrec,
                       input int tail, input bit bad_cs);
    logic [7:0] x;
    frm.delete();
    for (int i = 0; i < HO; i++) frm.push_back(8'(i * 7 + 1));
    for (int j = 3; j >= 0; j--) frm.push_back(mg[8*j +: 8]);
    frm.push_back(8'(nch_field));
    for (int j = 2; j >= 0; j--) frm.push_back(g_sp[8*j +: 8]);
    for (int k = 0; k < nrec; k++) begin
      for (int j = 3; j >= 0; j--) frm.push_back(r_thr[k][8*j +: 8]);
      frm.push_back(r_fft[k]);
      frm.push_back(r_mode[k]);
      for (int j = 3; j >= 0; j--) frm.push_back(r_freq[k][8*j +: 8]);
      frm.push_back(r_sp[k][15:8]);
      frm.push_back(r_sp[k][7:0]);
    end
    if (CS == 1) begin
      x = 8'd0;
      for (int i = HO; i < frm.size(); i++) x = x ^ frm[i];
      if (bad_cs) x = x ^ 8'h01;
      frm.push_back(x);
    end
    for (int t = 0; t < tail; t++) frm.push_back(8'h55);
  endtask

  task automatic push_result(input logic [2:0] code);
    if (code == 3'd0) m.good = m.good + 16'd1;
    else begin
      m.bad  = m.bad + 16'd1;
      m.code = code;
    end
    m.err = (code != 3'd0);
    exp_q.push_back(m);
  endtask

  task automatic model_frame();
    int          last, n, need, b;
    logic [31:0] mg;
    logic [7:0]  x;
    logic [2:0]  code;
    last = frm.size() - 1;
    mg   = {frm[HO], frm[HO+1], frm[HO+2], frm[HO+3]};
    n    = int'(frm[HO+4]);
    need = HO + 7 + 12 * n + CS;
    code = 3'd0;
    if (mg != MAGIC) code = 3'd1;
    else if (n == 0 || n > NCH) code = 3'd2;
    else if (last < need) code = 3'd3;
    else if (CS == 1) begin
      x = 8'd0;
      for (int i = HO; i <= HO + 7 + 12 * n; i++) x = x ^ frm[i];
      if (x != frm[HO + 8 + 12 * n]) code = 3'd6;
    end
    if (code == 3'd0) begin
      m.nch = frm[HO+4];
      m.sp  = {frm[HO+5], frm[HO+6], frm[HO+7]};
      for (int k = 0; k < n; k++) begin
        b = HO + 8 + 12 * k;
        m.thr[32*k +: 32]  = {frm[b], frm[b+1], frm[b+2], frm[b+3]};
        m.fft[8*k +: 8]    = frm[b+4];
        m.mode[8*k +: 8]   = frm[b+5];
        m.freq[32*k +: 32] = {frm[b+6], frm[b+7], frm[b+8], frm[b+9]};
        m.csp[16*k +: 16]  = {frm[b+10], frm[b+11]};
      end
    end
    push_result(code);
  endtask

  // Drive bytes 0..last_i of frm; stall0 returns how many cycles the first byte was held off.
  task automatic send(input int last_i, input bit eof_last, input int gap, input bit keep,
                      output int stall0);
    int st;
    bit timed_out;
    stall0    = 0;
    timed_out = 1'b0;
    for (int i = 0; i <= last_i; i++) begin
      if (i > 0 && gap > 0) begin
        @(negedge clk);
        ll.src_rdy_n = 1'b1;
        repeat (gap - 1) @(negedge clk);
      end
      @(negedge clk);
      ll.data_in   = frm[i];
      ll.sof_n     = (i != 0);
      ll.eof_n     = !(eof_last && i == last_i);
      ll.src_rdy_n = 1'b0;
      st = 0;
      while (ll.dst_rdy_n !== 1'b0 && st < 20) begin
        @(negedge clk);
        st++;
      end
      if (st >= 20) timed_out = 1'b1;
      if (i == 0) stall0 = st;
      @(posedge clk);
    end
    chk("rdy_wait", timed_out, 0);
    if (!keep) begin
      @(negedge clk);
      ll.src_rdy_n = 1'b1;
      ll.sof_n     = 1'b1;
      ll.eof_n     = 1'b1;
    end
  endtask

  task automatic send_frame(input int gap, input bit keep, output int stall0);
    send(frm.size() - 1, 1'b1, gap, keep, stall0);
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(negedge clk);
    chk("drain", exp_q.size(), 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && (cfg_valid || cfg_err)) begin
        chk("vld_err_excl", cfg_valid & cfg_err, 0);
        chk("evt_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("cfg_err", cfg_err, e.err);
          chk("cfg_valid", cfg_valid, !e.err);
          chk("err_code", err_code, e.code);
          chk("good_cnt", good_cnt, e.good);
          chk("bad_cnt", bad_cnt, e.bad);
          chk("gen_num_ch", gen_num_ch, e.nch);
          chk("gen_spare", gen_spare, e.sp);
          chk("ch_threshold", ch_threshold, e.thr);
          chk("ch_fft_size", ch_fft_size, e.fft);
          chk("ch_mode", ch_mode, e.mode);
          chk("ch_frequency", ch_frequency, e.freq);
          chk("ch_spare", ch_spare, e.csp);
        end
      end
    end
  end

  initial begin : stim
    int st;
    m = '{default: '0};
    ll.data_in = 8'd0; ll.sof_n = 1'b1; ll.eof_n = 1'b1; ll.src_rdy_n = 1'b1;
    g_sp = 24'h102030;
    for (int k = 0; k < 8; k++) set_rec(k, 32'h0, 8'h0, 8'h0, 32'h0, 16'h0);

    #2 rst_n = 1'b0;
    #1;
    chk("rst_dst_rdy_n", ll.dst_rdy_n, 1);
    chk("rst_good", good_cnt, 0);
    chk("rst_bad", bad_cnt, 0);
    chk("rst_flags", {cfg_valid, cfg_err, err_code}, 0);
    chk("rst_thr", ch_threshold, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Two-channel frame from the reference scenario.
    set_rec(0, 32'h11223344, 8'h40, 8'h01, 32'h55667788, 16'hAABB);
    set_rec(1, 32'h01020304, 8'h80, 8'h02, 32'h0A0B0C0D, 16'hCCDD);
    build(MAGIC, 2, 2, 0, 1'b0); model_frame(); send_frame(0, 0, st);
    drain();
    chk("f1_ch1_thr", ch_threshold[63:32], 32'h01020304);
    chk("f1_ch1_freq", ch_frequency[63:32], 32'h0A0B0C0D);
    chk("f1_ch23_thr", ch_threshold[127:64], 0);
    chk("f1_good", good_cnt, 1);

    g_sp = 24'hEEEEEE;
    build(32'hDEADBEEE, 2, 2, 0, 1'b0); model_frame(); send_frame(0, 0, st);
    set_rec(4, 32'h99, 8'h1, 8'h1, 32'h99, 16'h1);
    build(MAGIC, 5, 5, 0, 1'b0); model_frame(); send_frame(0, 0, st);
    build(MAGIC, 0, 0, 4, 1'b0); model_frame(); send_frame(0, 0, st);
    build(MAGIC, 2, 2, 0, 1'b0); frm = frm[0:HO+20]; model_frame(); send_frame(0, 0, st);
    drain();
    chk("err3_code", err_code, 3);
    chk("err_bad", bad_cnt, 4);

    // All four channels, first with gaps, then gap-free.
    g_sp = 24'h0A0B0C;
    for (int k = 0; k < 4; k++)
      set_rec(k, 32'hC0DE0000 + 32'(k), 8'(16 << k), 8'(k + 3), 32'h100000 * 32'(k + 1), 16'(k * 257));
    build(MAGIC, 4, 4, 0, 1'b0); model_frame(); send_frame(3, 0, st);
    build(MAGIC, 4, 4, 0, 1'b0); model_frame(); send_frame(0, 0, st);

    // One channel plus trailing bytes: only ch0 changes.
    set_rec(0, 32'hFFFF0001, 8'hFF, 8'h7F, 32'h80000001, 16'hFFFF);
    build(MAGIC, 1, 1, 6, 1'b0); model_frame(); send_frame(0, 0, st);

    // Idle timeout mid-frame, then recovery.
    build(MAGIC, 2, 2, 0, 1'b0);
    push_result(3'd5);
    send(HO + 10, 1'b0, 0, 1'b0, st);
    repeat (TO + 10) @(negedge clk);
    chk("to_idle_rdy", ll.dst_rdy_n, 0);
    set_rec(1, 32'h0BADF00D, 8'h20, 8'h09, 32'h12345678, 16'h4321);
    build(MAGIC, 2, 2, 0, 1'b0); model_frame(); send_frame(0, 0, st);

    // SOF inside a frame aborts it; the new frame commits.
    build(MAGIC, 3, 3, 0, 1'b0);
    push_result(3'd4);
    send(HO + 10, 1'b0, 0, 1'b1, st);
    set_rec(2, 32'h22222222, 8'h22, 8'h22, 32'h33333333, 16'h2233);
    build(MAGIC, 3, 3, 0, 1'b0); model_frame(); send_frame(0, 0, st);
    chk("restart_stall", st, 0);

    // Back-to-back: the second SOF lands in the CHECK cycle.
    set_rec(0, 32'hA0A0A0A0, 8'hA0, 8'hA0, 32'hA0A0A0A0, 16'hA0A0);
    build(MAGIC, 1, 1, 0, 1'b0); model_frame(); send_frame(0, 1, st);
    set_rec(0, 32'hB0B0B0B0, 8'hB0, 8'hB0, 32'hB0B0B0B0, 16'hB0B0);
    build(MAGIC, 2, 2, 0, 1'b0); model_frame(); send_frame(0, 0, st);
    chk("b2b_stall", st, 1);

`ifdef ETH_CFG_CSUM_EN
    build(MAGIC, 2, 2, 0, 1'b1); model_frame(); send_frame(0, 0, st);
    drain();
    chk("csum_err_code", err_code, 6);
`endif
    drain();

    // Reset in the middle of a frame.
    build(MAGIC, 2, 2, 0, 1'b0);
    send(HO + 15, 1'b0, 0, 1'b1, st);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_dst_rdy_n", ll.dst_rdy_n, 1);
    chk("mid_rst_cnts", {good_cnt, bad_cnt}, 0);
    chk("mid_rst_outs", {ch_threshold, ch_frequency}, 0);
    chk("mid_rst_gen", {gen_num_ch, gen_spare, err_code}, 0);
    ll.src_rdy_n = 1'b1; ll.sof_n = 1'b1; ll.eof_n = 1'b1;
    m = '{default: '0};
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    build(MAGIC, 2, 2, 0, 1'b0); model_frame(); send_frame(0, 0, st);
    drain();
    chk("post_rst_good", good_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
